// File: rtl/epb_pkg.sv
// Shared definitions for the Wishbone-to-EPB master bridge: FSM state
// encoding and EPB bus widths.
package epb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETUP   = 2'd1,
    STROBE  = 2'd2,
    RECOVER = 2'd3
  } epb_state_t;

  localparam int EPB_ADDR_W = 5;
  localparam int EPB_DATA_W = 8;
  localparam logic [EPB_DATA_W-1:0] EPB_TIMEOUT_DATA = 8'hFF;

endpackage

// File: rtl/epb_timeout_ctr.sv
// Wait-state counter for the EPB strobe phase; flags expiry when the next
// edge would bring the count to TIMEOUT_CYCLES.
module epb_timeout_ctr #(
  parameter int TO_W           = 8,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [TO_W-1:0] cnt_q, cnt_d;

  assign expired = enable && (cnt_q == TO_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable && !expired) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/wb_epb_master.sv
// Wishbone slave to EPB master bridge: one registered EPB transaction per
// Wishbone cycle, completed by rdy or aborted by timeout.
module wb_epb_master
  import epb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int TO_W           = 8,
  parameter int RECOVER_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wb_cyc_i,
  input  logic                  wb_stb_i,
  input  logic                  wb_we_i,
  input  logic                  wb_sel_i,
  input  logic [EPB_ADDR_W-1:0] wb_adr_i,
  input  logic [EPB_DATA_W-1:0] wb_dat_i,
  output logic [EPB_DATA_W-1:0] wb_dat_o,
  output logic                  wb_ack_o,
  output logic                  wb_err_o,
  output logic                  epb_cs_n,
  output logic                  epb_oe_n,
  output logic                  epb_we_n,
  output logic                  epb_be_n,
  output logic [EPB_ADDR_W-1:0] epb_addr,
  output logic [EPB_DATA_W-1:0] epb_data_o,
  output logic                  epb_data_oe,
  input  logic [EPB_DATA_W-1:0] epb_data_i,
  input  logic                  epb_rdy_i
);

  localparam int RC_W = (RECOVER_CYCLES > 1) ? $clog2(RECOVER_CYCLES) : 1;

  epb_state_t            state_q, state_d;
  logic [RC_W-1:0]       rcnt_q, rcnt_d;
  logic                  we_q, we_d;
  logic                  cs_n_q, cs_n_d, oe_n_q, oe_n_d, we_n_q, we_n_d, be_n_q, be_n_d;
  logic [EPB_ADDR_W-1:0] addr_q, addr_d;
  logic [EPB_DATA_W-1:0] data_o_q, data_o_d, dat_o_q, dat_o_d;
  logic                  data_oe_q, data_oe_d, ack_q, ack_d, err_q, err_d;
  logic                  to_clear, to_en, to_expired;

  epb_timeout_ctr #(
    .TO_W          (TO_W),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (clk),
    .reset  (reset),
    .clear  (to_clear),
    .enable (to_en),
    .expired(to_expired)
  );

  always_comb begin
    state_d   = state_q;
    rcnt_d    = rcnt_q;
    we_d      = we_q;
    cs_n_d    = cs_n_q;
    oe_n_d    = oe_n_q;
    we_n_d    = we_n_q;
    be_n_d    = be_n_q;
    addr_d    = addr_q;
    data_o_d  = data_o_q;
    data_oe_d = data_oe_q;
    dat_o_d   = dat_o_q;
    ack_d     = 1'b0;
    err_d     = 1'b0;
    to_clear  = 1'b0;
    to_en     = 1'b0;
    case (state_q)
      IDLE: begin
        if (wb_cyc_i && wb_stb_i) begin
          we_d      = wb_we_i;
          addr_d    = wb_adr_i;
          data_o_d  = wb_dat_i;
          we_n_d    = !wb_we_i;
          be_n_d    = !wb_sel_i;
          data_oe_d = wb_we_i;
          state_d   = SETUP;
        end
      end
      SETUP: begin
        cs_n_d   = 1'b0;
        oe_n_d   = we_q;
        to_clear = 1'b1;
        state_d  = STROBE;
      end
      STROBE: begin
        to_en = 1'b1;
        if (epb_rdy_i || to_expired) begin
          cs_n_d    = 1'b1;
          oe_n_d    = 1'b1;
          we_n_d    = 1'b1;
          be_n_d    = 1'b1;
          data_oe_d = 1'b0;
          rcnt_d    = '0;
          state_d   = RECOVER;
          // rdy takes priority when it coincides with expiry
          if (epb_rdy_i) begin
            ack_d = wb_cyc_i;
            if (!we_q) dat_o_d = epb_data_i;
          end else begin
            err_d = wb_cyc_i;
            if (!we_q) dat_o_d = EPB_TIMEOUT_DATA;
          end
        end
      end
      RECOVER: begin
        if (rcnt_q == RC_W'(RECOVER_CYCLES - 1)) begin
          state_d = IDLE;
        end else begin
          rcnt_d = rcnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      rcnt_q    <= '0;
      we_q      <= 1'b0;
      cs_n_q    <= 1'b1;
      oe_n_q    <= 1'b1;
      we_n_q    <= 1'b1;
      be_n_q    <= 1'b1;
      addr_q    <= '0;
      data_o_q  <= '0;
      data_oe_q <= 1'b0;
      dat_o_q   <= '0;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      rcnt_q    <= rcnt_d;
      we_q      <= we_d;
      cs_n_q    <= cs_n_d;
      oe_n_q    <= oe_n_d;
      we_n_q    <= we_n_d;
      be_n_q    <= be_n_d;
      addr_q    <= addr_d;
      data_o_q  <= data_o_d;
      data_oe_q <= data_oe_d;
      dat_o_q   <= dat_o_d;
      ack_q     <= ack_d;
      err_q     <= err_d;
    end
  end

  assign epb_cs_n    = cs_n_q;
  assign epb_oe_n    = oe_n_q;
  assign epb_we_n    = we_n_q;
  assign epb_be_n    = be_n_q;
  assign epb_addr    = addr_q;
  assign epb_data_o  = data_o_q;
  assign epb_data_oe = data_oe_q;
  assign wb_dat_o    = dat_o_q;
  assign wb_ack_o    = ack_q;
  assign wb_err_o    = err_q;

endmodule
